// File: rtl/uart_cmd_slave.sv
// UART command responder: 2-byte write/read command frames on rx, a small register file,
// and a single data frame answered on tx for reads. Optional macro UART_SLV_WR_ACK_EN adds a write ack byte.
module uart_cmd_slave #(
    parameter int BR      = 434,
    parameter int ADDR_W  = 4,
    parameter int RSP_DLY = 400,
    parameter int TIMEOUT = 8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    output logic              wr_vld,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              err_parity,
    output logic              err_frame,
    output logic              busy
);

    localparam int REG_NUM = 2 ** ADDR_W;
    localparam int BAUD_W  = $clog2(BR);
    localparam int CNT_MAX = (TIMEOUT > RSP_DLY) ? ((TIMEOUT > BR) ? TIMEOUT : BR)
                                                 : ((RSP_DLY > BR) ? RSP_DLY : BR);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;
    typedef enum logic [2:0] {C_WAIT0, C_WAIT1, C_EXEC, C_DLY, C_TX} cmd_state_e;

    // ------------------------------------------------------------------ RX path
    logic [2:0]        sync_q, sync_d;
    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_par_err_q, rx_par_err_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_good_q, rx_good_d;
    logic              rx_s, rx_fall, rx_tick, stop_sample;

    assign rx_s    = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];
    assign rx_tick = (rx_baud_q == BAUD_W'(BR - 1));

    // NOTE: every variable gets its default first, so no path through the case can infer a latch.
    always_comb begin
        sync_d       = {sync_q[1:0], rx};
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_err_d = rx_par_err_q;
        rx_done_d    = 1'b0;
        rx_good_d    = 1'b0;
        stop_sample  = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                rx_baud_d = '0;
                if (rx_fall) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_baud_q == BAUD_W'(BR / 2)) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? R_IDLE : R_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            R_DATA: begin
                rx_baud_d = rx_tick ? '0 : rx_baud_q + 1'b1;
                if (rx_tick) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_PAR;
                end
            end
            R_PAR: begin
                rx_baud_d = rx_tick ? '0 : rx_baud_q + 1'b1;
                if (rx_tick) begin
                    rx_par_err_d = (rx_s != ~^rx_shift_q);
                    rx_state_d   = R_STOP;
                end
            end
            R_STOP: begin
                rx_baud_d = rx_tick ? '0 : rx_baud_q + 1'b1;
                if (rx_tick) begin
                    stop_sample = 1'b1;
                    rx_done_d   = 1'b1;
                    rx_good_d   = rx_s & ~rx_par_err_q;
                    rx_state_d  = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 3'b111;  // idle-high line, so reset release never looks like a start edge
            rx_state_q   <= R_IDLE;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_err_q <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_good_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rx_state_q   <= rx_state_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_err_q <= rx_par_err_d;
            rx_done_q    <= rx_done_d;
            rx_good_q    <= rx_good_d;
        end
    end

    // ------------------------------------------------------------ command FSM
    cmd_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [9:0]        tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic              in_range_q, in_range_d;
    logic [7:0]        regs_q [REG_NUM];
    logic [7:0]        regs_d [REG_NUM];
    logic [7:0]        rsp_byte;
    logic              timeout_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = 1'b1;
        data_d      = data_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        in_range_d  = in_range_q;
        regs_d      = regs_q;
        rsp_byte    = 8'h00;
        wr_vld      = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            C_WAIT0: begin
                cnt_d = '0;
                if (rx_done_q && rx_good_q) begin
                    data_d  = rx_shift_q;
                    state_d = C_WAIT1;
                end
            end
            C_WAIT1: begin
                if (rx_done_q) begin
                    cnt_d = '0;
                    if (rx_good_q) begin
                        is_wr_d    = rx_shift_q[7];
                        addr_d     = rx_shift_q[ADDR_W-1:0];
                        in_range_d = (int'(rx_shift_q[6:0]) < REG_NUM);
                        state_d    = C_EXEC;
                    end else begin
                        state_d = C_WAIT0;
                    end
                end else if (rx_state_q == R_IDLE && !rx_fall) begin
                    // The gap is only timed while the line is quiet; a start bit freezes the count.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_hit = 1'b1;
                        cnt_d       = '0;
                        state_d     = C_WAIT0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            C_EXEC: begin
                cnt_d    = '0;
                tx_bit_d = '0;
                if (is_wr_q) begin
                    if (in_range_q) begin
                        wr_vld         = 1'b1;
                        regs_d[addr_q] = data_q;
                    end
`ifdef UART_SLV_WR_ACK_EN
                    rsp_byte = in_range_q ? 8'hA5 : 8'h5A;
                    state_d  = C_DLY;
`else
                    state_d  = C_WAIT0;
`endif
                end else begin
                    rsp_byte = in_range_q ? regs_q[addr_q] : 8'h00;
                    state_d  = C_DLY;
                end
                tx_shift_d = {1'b1, ~^rsp_byte, rsp_byte};
            end
            C_DLY: begin
                // Leaving one cycle early lets the registered tx show the start bit on cycle RSP_DLY.
                if (cnt_q == CNT_W'(RSP_DLY - 2)) begin
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = C_TX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_TX: begin
                tx_d = tx_q;
                if (cnt_q == CNT_W'(BR - 1)) begin
                    cnt_d = '0;
                    if (tx_bit_q == 4'd10) begin
                        tx_d     = 1'b1;
                        tx_bit_d = '0;
                        state_d  = C_WAIT0;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = C_WAIT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_WAIT0;
            cnt_q      <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
            data_q     <= '0;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            in_range_q <= in_range_d;
        end
    end

    // NOTE: the register file must clear on reset, so it is built from resettable flops, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign tx         = tx_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign host_rdata = regs_q[host_addr];
    assign busy       = (state_q != C_WAIT0);
    assign err_parity = stop_sample & rx_par_err_q;
    assign err_frame  = (stop_sample & ~rx_s) | timeout_hit;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: random and directed commands, a reference register-file
// model, and independent monitors for writes, tx frames and error pulses.
module tb_uart_cmd_slave;

    localparam int BR      = 16;
    localparam int ADDR_W  = 4;
    localparam int RSP_DLY = 40;
    localparam int TIMEOUT = 400;
    localparam int REG_NUM = 2 ** ADDR_W;
    localparam int LAT_MIN = 1;   // allowed offset from the ideal stop-bit midpoint (input synchroniser)
    localparam int LAT_MAX = 5;
    localparam int CMD_GAP = RSP_DLY + 11 * BR + 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              tx;
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic              err_parity;
    logic              err_frame;
    logic              busy;

    uart_cmd_slave #(.BR(BR), .ADDR_W(ADDR_W), .RSP_DLY(RSP_DLY), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .wr_vld    (wr_vld),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [7:0]        old;
        int unsigned       ideal;
    } wr_exp_t;

    typedef struct {
        logic [7:0]  data;
        int unsigned ideal;
    } tx_exp_t;

    typedef struct {
        int unsigned ideal;
        int          late_max;
    } err_exp_t;

    wr_exp_t  wr_exp_q [$];
    tx_exp_t  tx_exp_q [$];
    err_exp_t par_exp_q[$];
    err_exp_t frm_exp_q[$];

    logic [7:0] model [REG_NUM];
    logic       tx_mon_en;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: offset %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Drives one frame starting at the current negedge.
    task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    function automatic int unsigned stop_mid(input int unsigned start);
        return start + 10 * BR + BR / 2;
    endfunction

    // Full command with reference-model expectations.
    task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1);
        logic [ADDR_W-1:0] a;
        logic              in_rng;
        int unsigned       s1;
        int unsigned       exec_ideal;
        wr_exp_t           we;
        tx_exp_t           te;
        a         = b1[ADDR_W-1:0];
        in_rng    = (int'(b1[6:0]) < REG_NUM);
        host_addr = a;
        send_byte(b0, 1'b0, 1'b0);
        s1         = cyc;
        exec_ideal = stop_mid(s1) + 2;
        if (b1[7]) begin
            if (in_rng) begin
                we.addr  = a;
                we.data  = b0;
                we.old   = model[a];
                we.ideal = exec_ideal;
                wr_exp_q.push_back(we);
                model[a] = b0;
            end
`ifdef UART_SLV_WR_ACK_EN
            te.data  = in_rng ? 8'hA5 : 8'h5A;
            te.ideal = exec_ideal + RSP_DLY;
            tx_exp_q.push_back(te);
`endif
        end else begin
            te.data  = in_rng ? model[a] : 8'h00;
            te.ideal = exec_ideal + RSP_DLY;
            tx_exp_q.push_back(te);
        end
        send_byte(b1, 1'b0, 1'b0);
        repeat (CMD_GAP) @(negedge clk);
        check("host_rdata_after_cmd", host_rdata, model[a]);
        check("busy_idle_after_cmd", busy, 1'b0);
    endtask

    // ---------------------------------------------------------------- monitors
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && wr_vld) begin
                if (wr_exp_q.size() == 0) begin
                    unexpected("wr_vld");
                end else begin
                    e = wr_exp_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check_win("wr_latency", int'(cyc) - int'(e.ideal), LAT_MIN, LAT_MAX);
                    check("host_rdata_old_in_write_cycle", host_rdata, e.old);
                    @(negedge clk);
                    check("wr_vld_single_pulse", wr_vld, 1'b0);
                    check("host_rdata_new_after_write", host_rdata, e.data);
                end
            end
        end
    end

    initial begin
        tx_exp_t     e;
        int unsigned t0;
        logic        st, par, stp, busy_mid;
        logic [7:0]  d;
        forever begin
            @(negedge clk);
            if (!rst && tx_mon_en && tx === 1'b0) begin
                t0 = cyc;
                repeat (BR / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BR) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BR) @(negedge clk);
                par = tx;
                repeat (BR) @(negedge clk);
                stp      = tx;
                busy_mid = busy;
                if (tx_mon_en) begin
                    if (tx_exp_q.size() == 0) begin
                        unexpected("tx_frame");
                    end else begin
                        e = tx_exp_q.pop_front();
                        check_win("tx_start_latency", int'(t0) - int'(e.ideal), LAT_MIN, LAT_MAX);
                        check("tx_start_bit", st, 1'b0);
                        check("tx_data", d, e.data);
                        check("tx_parity", par, ~^e.data);
                        check("tx_stop_bit", stp, 1'b1);
                        check("busy_during_tx", busy_mid, 1'b1);
                        repeat (BR / 2 + 2) @(negedge clk);
                        check("busy_after_tx", busy, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        err_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && err_parity) begin
                if (par_exp_q.size() == 0) unexpected("err_parity");
                else begin
                    e = par_exp_q.pop_front();
                    check_win("err_parity_time", int'(cyc) - int'(e.ideal), LAT_MIN, e.late_max);
                end
            end
            if (!rst && err_frame) begin
                if (frm_exp_q.size() == 0) unexpected("err_frame");
                else begin
                    e = frm_exp_q.pop_front();
                    check_win("err_frame_time", int'(cyc) - int'(e.ideal), 0, e.late_max);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        err_exp_t    ee;
        int unsigned s;
        logic [7:0]  b0, b1;
        bit          got;

        rx        = 1'b1;
        rst       = 1'b1;
        host_addr = '0;
        tx_mon_en = 1'b1;
        for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_tx", tx, 1'b1);
        check("reset_wr_vld", wr_vld, 1'b0);
        check("reset_wr_addr", wr_addr, '0);
        check("reset_wr_data", wr_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_err_parity", err_parity, 1'b0);
        check("reset_err_frame", err_frame, 1'b0);
        for (int i = 0; i < REG_NUM; i++) begin
            host_addr = ADDR_W'(i);
            #1;
            check("reset_regfile", host_rdata, 8'h00);
        end
        @(negedge clk);

        // Directed write, read-back, out-of-range and write-ack cases.
        do_cmd(8'h3C, 8'h85);
        do_cmd(8'h00, 8'h05);
        do_cmd(8'h77, 8'h90);
        do_cmd(8'h00, 8'h20);
        do_cmd(8'h11, 8'h82);

        // Parity error on byte0: no command starts.
        ee.ideal = stop_mid(cyc); ee.late_max = LAT_MAX;
        par_exp_q.push_back(ee);
        send_byte(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("busy_after_parity_err", busy, 1'b0);

        // Good byte0, parity error on byte1: partial command discarded.
        send_byte(8'h99, 1'b0, 1'b0);
        ee.ideal = stop_mid(cyc); ee.late_max = LAT_MAX;
        par_exp_q.push_back(ee);
        send_byte(8'h83, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("busy_after_byte1_parity_err", busy, 1'b0);

        // Stop-bit error.
        ee.ideal = stop_mid(cyc); ee.late_max = LAT_MAX;
        frm_exp_q.push_back(ee);
        send_byte(8'h3C, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("busy_after_stop_err", busy, 1'b0);

        // Byte0 then silence: timeout.
        s = cyc;
        ee.ideal = stop_mid(s) + TIMEOUT; ee.late_max = 8;
        frm_exp_q.push_back(ee);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        check("busy_waiting_byte1", busy, 1'b1);
        repeat (TIMEOUT) @(negedge clk);
        check("busy_after_timeout", busy, 1'b0);

        // Short low glitch on rx: nothing happens.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("busy_after_glitch", busy, 1'b0);
        check("regfile_after_glitch", host_rdata, model[host_addr]);

        // Randomised command mix.
        for (int n = 0; n < 24; n++) begin
            b0 = 8'($urandom);
            b1[7] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) b1[6:0] = 7'($urandom_range(REG_NUM, 127));
            else                           b1[6:0] = 7'($urandom_range(0, REG_NUM - 1));
            do_cmd(b0, b1);
            host_addr = ADDR_W'($urandom_range(0, REG_NUM - 1));
            #1;
            check("host_rdata_random", host_rdata, model[host_addr]);
            @(negedge clk);
        end

        // Reset during data bit 3 of a read response.
        do_cmd(8'h3C, 8'h85);
        tx_mon_en = 1'b0;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 4 * RSP_DLY && !got; i++) begin
            @(negedge clk);
            if (tx === 1'b0) got = 1'b1;
        end
        check("rst_test_tx_start_seen", got, 1'b1);
        repeat (4 * BR + BR / 2) @(negedge clk);
        check("rst_test_tx_bit3", tx, 1'b1);
        check("rst_test_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_test_tx_idle", tx, 1'b1);
        check("rst_test_busy_clear", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;
        host_addr = ADDR_W'(5);
        @(negedge clk);
        check("rst_test_regfile_cleared", host_rdata, 8'h00);
        repeat (2 * BR) @(negedge clk);
        tx_mon_en = 1'b1;

        // Operation resumes after reset.
        do_cmd(8'hA7, 8'h89);
        do_cmd(8'h00, 8'h09);
        do_cmd(8'h00, 8'h05);

        repeat (50) @(negedge clk);
        check("wr_queue_drained", wr_exp_q.size(), 0);
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("parity_queue_drained", par_exp_q.size(), 0);
        check("frame_queue_drained", frm_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
